// File: rtl/comm_arb_pkg.sv
// comm_arb_pkg: shared types and constants for the CommMaster arbiter.
//   arb_state_t        transaction FSM states
//   CMD_W / RESP_W     command and response widths
//   RESP_TIMEOUT_BYTE  byte returned when a response times out
package comm_arb_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;
  localparam logic [7:0]  RESP_TIMEOUT_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_CMPLT,
    WAIT_RESP,
    DONE
  } arb_state_t;

endpackage

// File: rtl/comm_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin requester selection with a rotating last-grant pointer.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req         per-requester request levels
//   upd         strobe: commit the current winner as the new last-grant
//   grant_next  one-hot winner, searching from last-grant+1 with wrap
//   valid       at least one request is pending
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  output logic [NUM_REQ-1:0] grant_next,
  output logic               valid
);

  localparam int unsigned     PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0]     N_W     = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0]   PTR_RST = PW'(NUM_REQ - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;

  // Walk ptr+1 .. ptr+NUM_REQ with a subtract-wrap instead of a modulo,
  // so non-power-of-two requester counts stay cheap.
  always_comb begin
    grant_next = '0;
    valid      = 1'b0;
    win_idx    = ptr_q;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!valid && req[cand[PW-1:0]]) begin
        valid                      = 1'b1;
        win_idx                    = cand[PW-1:0];
        grant_next[cand[PW-1:0]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_RST;
    end else if (upd && valid) begin
      ptr_q <= win_idx;
    end
  end

endmodule

// File: rtl/comm_arbiter.sv
// comm_arbiter: shares one CommMaster among NUM_REQ requesters. Round-robin
// arbitration, one 16-bit command per transaction, one response byte returned
// to the owner with a single-cycle done pulse.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req              per-requester request levels
//   req_cmd          packed commands, requester i at [16i+15:16i]
//   gnt              one-hot owner of the current transaction
//   done             one-cycle pulse to the owner at transaction end
//   resp_out         response byte (holds last value between transactions)
//   resp_err         high with done when the response timed out
//   busy             high whenever the FSM is not idle
//   cm_cmd           command to CommMaster
//   cm_snd_cmd       launch pulse to CommMaster
//   cm_clr_resp_rdy  clears CommMaster response-ready
//   cm_cmd_cmplt     CommMaster transmit complete (level)
//   cm_rdy           CommMaster response available (sticky level)
//   cm_resp          CommMaster response byte
// Build option: define RESP_TIMEOUT_EN to enable the TIMEOUT_CYCLES response
// timeout; otherwise the block waits indefinitely and resp_err stays 0.
module comm_arbiter
  import comm_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [16*NUM_REQ-1:0]    req_cmd,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [7:0]               resp_out,
  output logic                     resp_err,
  output logic                     busy,
  output logic [15:0]              cm_cmd,
  output logic                     cm_snd_cmd,
  output logic                     cm_clr_resp_rdy,
  input  logic                     cm_cmd_cmplt,
  input  logic                     cm_rdy,
  input  logic [7:0]               cm_resp
);

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_valid;
  logic                 arb_upd;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [CMD_W-1:0]     cmd_q;
  logic [CMD_W-1:0]     cmd_sel;
  logic [RESP_W-1:0]    resp_q;
  logic                 err_q;
  logic                 tmo;

  assign arb_upd = (state_q == IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .upd        (arb_upd),
    .grant_next (arb_gnt),
    .valid      (arb_valid)
  );

  always_comb begin
    cmd_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        cmd_sel = req_cmd[i*CMD_W +: CMD_W];
      end
    end
  end

`ifdef RESP_TIMEOUT_EN
  localparam int unsigned TCW =
    ($clog2(TIMEOUT_CYCLES) + 1 > 20) ? $clog2(TIMEOUT_CYCLES) + 1 : 20;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [TCW-1:0] tcnt_q;
  logic [TCW-1:0] tcnt_inc;

  assign tcnt_inc = tcnt_q + TCW'(1);
  // Fires on the edge where the counter steps onto TIMEOUT_CYCLES-1, which
  // places DONE exactly TIMEOUT_CYCLES cycles after SEND.
  assign tmo = ((state_q == WAIT_CMPLT) || (state_q == WAIT_RESP)) &&
               (tcnt_inc == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (state_q == SEND) begin
      tcnt_q <= '0;
    end else if ((state_q == WAIT_CMPLT) || (state_q == WAIT_RESP)) begin
      tcnt_q <= tcnt_inc;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; timeout takes precedence in WAIT_CMPLT since the
  // counter would step past its terminal value after leaving that state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (arb_valid) state_d = SEND;
      SEND:       state_d = WAIT_CMPLT;
      WAIT_CMPLT: begin
        if (tmo)               state_d = DONE;
        else if (cm_cmd_cmplt) state_d = WAIT_RESP;
      end
      WAIT_RESP:  if (cm_rdy || tmo) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Transaction datapath: owner, command, captured response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      cmd_q  <= '0;
      resp_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q <= arb_gnt;
            cmd_q <= cmd_sel;
          end
        end
        WAIT_CMPLT: begin
          if (tmo) begin
            resp_q <= RESP_TIMEOUT_BYTE;
            err_q  <= 1'b1;
          end
        end
        WAIT_RESP: begin
          // A real byte arriving with the timeout wins.
          if (cm_rdy) begin
            resp_q <= cm_resp;
            err_q  <= 1'b0;
          end else if (tmo) begin
            resp_q <= RESP_TIMEOUT_BYTE;
            err_q  <= 1'b1;
          end
        end
        DONE: begin
          gnt_q <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    done            = '0;
    cm_snd_cmd      = 1'b0;
    cm_clr_resp_rdy = 1'b0;
    resp_err        = 1'b0;
    busy            = (state_q != IDLE);
    case (state_q)
      SEND: begin
        cm_snd_cmd      = 1'b1;
        cm_clr_resp_rdy = 1'b1;
      end
      DONE: begin
        done            = gnt_q;
        cm_clr_resp_rdy = 1'b1;
        resp_err        = err_q;
      end
      default: ;
    endcase
  end

  assign gnt      = gnt_q;
  assign cm_cmd   = cmd_q;
  assign resp_out = resp_q;

endmodule

// File: tb/tb_comm_arbiter.sv
// tb_comm_arbiter: directed and randomized bench for comm_arbiter with a
// transaction-level reference model (round-robin rule + CommMaster responder).
module tb_comm_arbiter;
  localparam int unsigned N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [16*N-1:0] req_cmd;
  logic [N-1:0]    gnt, done;
  logic [7:0]      resp_out;
  logic            resp_err, busy;
  logic [15:0]     cm_cmd;
  logic            cm_snd_cmd, cm_clr_resp_rdy;
  logic            cm_cmd_cmplt, cm_rdy;
  logic [7:0]      cm_resp;

  int errors = 0;
  int checks = 0;

  comm_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd),
    .gnt(gnt), .done(done), .resp_out(resp_out), .resp_err(resp_err),
    .busy(busy), .cm_cmd(cm_cmd), .cm_snd_cmd(cm_snd_cmd),
    .cm_clr_resp_rdy(cm_clr_resp_rdy), .cm_cmd_cmplt(cm_cmd_cmplt),
    .cm_rdy(cm_rdy), .cm_resp(cm_resp)
  );

  initial forever #5 clk = ~clk;

  // Reference model state
  int unsigned last_ptr;
  bit          outstanding, model_idle, after_done;
  int unsigned owner;
  logic [15:0] exp_cmd;
  logic [7:0]  exp_resp, last_resp, forced_resp;
  bit          exp_err, use_forced, no_resp, hold_req, allow_tmo, rand_delays, chk_lat;
  int          cm_phase, cm_cnt, cfg_d1, cfg_d2, exp_lat;
  int          cyc, snd_cyc, txn_count;
  int unsigned grant_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned lp);
    for (int unsigned k = 1; k <= N; k++)
      if (r[(lp + k) % N]) return (lp + k) % N;
    return lp;
  endfunction

  task automatic tick();
    logic [N-1:0]    req_s;
    logic [16*N-1:0] cmd_s;
    bit              pred_snd;
    logic [7:0]      rsp;
    req_s    = req;
    cmd_s    = req_cmd;
    pred_snd = model_idle && (req_s != '0);
    @(posedge clk); #1;
    cyc++;
    if (pred_snd) begin
      owner       = rr_pick(req_s, last_ptr);
      last_ptr    = owner;
      exp_cmd     = cmd_s[owner*16 +: 16];
      outstanding = 1'b1;
      model_idle  = 1'b0;
      snd_cyc     = cyc;
      grant_log.push_back(owner);
    end
    if (after_done) begin
      model_idle = 1'b1;
      after_done = 1'b0;
    end
    chk("snd", 32'(cm_snd_cmd), 32'(pred_snd));
    chk("clr", 32'(cm_clr_resp_rdy), 32'(pred_snd || (done != '0)));
    chk("busy", 32'(busy), 32'(outstanding));
    chk("gnt", 32'(gnt), outstanding ? 32'(1 << owner) : 32'd0);
    if (outstanding) chk("cmd", 32'(cm_cmd), 32'(exp_cmd));
    if (done != '0) begin
      chk("done_owner", 32'(done), 32'(1 << owner));
      chk("done_valid", 32'(outstanding && (cm_phase == 3 || allow_tmo)), 32'd1);
      chk("resp", 32'(resp_out), 32'(exp_resp));
      chk("err", 32'(resp_err), 32'(exp_err));
      if (chk_lat) chk("latency", 32'(cyc - snd_cyc), 32'(exp_lat));
      last_resp   = exp_resp;
      outstanding = 1'b0;
      after_done  = 1'b1;
      txn_count++;
      cm_phase    = 0;
      if (!hold_req) req[owner] = 1'b0;
    end else begin
      chk("resp_hold", 32'(resp_out), 32'(last_resp));
      chk("err_idle", 32'(resp_err), 32'd0);
    end
    // CommMaster responder
    if (cm_clr_resp_rdy) cm_rdy = 1'b0;
    if (cm_snd_cmd) begin
      cm_cmd_cmplt = 1'b0;
      cm_phase     = 1;
      cm_cnt       = rand_delays ? int'($urandom_range(0, 3)) : cfg_d1;
    end
    case (cm_phase)
      1: if (cm_cnt <= 0) begin
           cm_cmd_cmplt = 1'b1;
           cm_phase     = 2;
           cm_cnt       = rand_delays ? int'($urandom_range(0, 3)) : cfg_d2;
         end else cm_cnt--;
      2: if (!no_resp) begin
           if (cm_cnt <= 0) begin
             rsp      = use_forced ? forced_resp : 8'($urandom);
             cm_rdy   = 1'b1;
             cm_resp  = rsp;
             exp_resp = rsp;
             exp_err  = 1'b0;
             cm_phase = 3;
           end else cm_cnt--;
         end
      default: ;
    endcase
  endtask

  task automatic wait_quiet(input int limit);
    int n = 0;
    while ((outstanding || after_done) && n < limit) begin
      tick();
      n++;
    end
    chk("quiet_timeout", 32'(outstanding || after_done), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resp", 32'(resp_out), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'(cm_cmd), 32'd0);
    chk("rst_snd", 32'(cm_snd_cmd), 32'd0);
    chk("rst_clr", 32'(cm_clr_resp_rdy), 32'd0);
    outstanding = 1'b0; after_done = 1'b0; model_idle = 1'b1;
    last_ptr = N - 1; last_resp = '0; exp_err = 1'b0; cm_phase = 0;
    cm_rdy = 1'b0; cm_cmd_cmplt = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n, start, s, c;
    int exp_ord[4];
    exp_ord = '{0, 1, 0, 1};
    req = '0; req_cmd = '0; cm_cmd_cmplt = 1'b0; cm_rdy = 1'b0; cm_resp = '0;
    use_forced = 1'b0; no_resp = 1'b0; hold_req = 1'b0; allow_tmo = 1'b0;
    rand_delays = 1'b1; chk_lat = 1'b0; cyc = 0; txn_count = 0;
    cfg_d1 = 0; cfg_d2 = 0; exp_lat = 0; forced_resp = '0; exp_resp = '0;

    // 1: single request
    do_reset();
    use_forced = 1'b1; forced_resp = 8'h3C;
    req_cmd[15:0] = 16'hA512; req = 3'b001;
    tick();
    chk("t1_cmd", 32'(cm_cmd), 32'h0000A512);
    wait_quiet(40);
    chk("t1_resp", 32'(resp_out), 32'h3C);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: contention, two requesters held continuously
    do_reset();
    use_forced = 1'b0; hold_req = 1'b1;
    req_cmd[15:0] = 16'h1111; req_cmd[31:16] = 16'h2222;
    s = grant_log.size(); start = txn_count; n = 0;
    req = 3'b011;
    while (txn_count < start + 4 && n < 200) begin tick(); n++; end
    req = '0; hold_req = 1'b0;
    wait_quiet(40);
    chk("t2_txns", 32'(txn_count - start), 32'd4);
    for (int k = 0; k < 4; k++) chk("t2_order", 32'(grant_log[s + k]), 32'(exp_ord[k]));

    // 3: stale response byte flushed by the SEND clear
    cm_rdy = 1'b1; cm_resp = 8'hFF;
    tick();
    use_forced = 1'b1; forced_resp = 8'h55;
    req_cmd[47:32] = 16'($urandom); req = 3'b100;
    tick();
    chk("t3_clr", 32'(cm_clr_resp_rdy), 32'd1);
    wait_quiet(40);
    chk("t3_resp", 32'(resp_out), 32'h55);

    // 4: request withdrawn after one cycle, command changed mid-transaction
    use_forced = 1'b0;
    c = int'($urandom_range(0, 65535));
    req_cmd[31:16] = 16'(c); req = 3'b010;
    start = txn_count;
    tick();
    req[1] = 1'b0; req_cmd[31:16] = ~16'(c);
    tick();
    chk("t4_cmd", 32'(cm_cmd), 32'(16'(c)));
    wait_quiet(40);
    chk("t4_done", 32'(txn_count - start), 32'd1);
    chk("t4_owner", 32'(grant_log[grant_log.size() - 1]), 32'd1);

    // 5: reset while waiting for the response
    rand_delays = 1'b0; cfg_d1 = 0; cfg_d2 = 30;
    req = 3'b001;
    repeat (5) tick();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    do_reset();
    tick();
    rand_delays = 1'b1;
    req = 3'b110;
    tick();
    wait_quiet(40);
    chk("t5_after", 32'(grant_log[grant_log.size() - 1]), 32'd1);

`ifdef RESP_TIMEOUT_EN
    // 6: response timeout, then timeout coincident with a real response
    rand_delays = 1'b0; cfg_d1 = 0; allow_tmo = 1'b1; chk_lat = 1'b1; exp_lat = 50;
    no_resp = 1'b1; exp_resp = 8'hEE; exp_err = 1'b1;
    req = 3'b001;
    tick();
    wait_quiet(80);
    chk("t6_resp", 32'(resp_out), 32'hEE);
    no_resp = 1'b0; cfg_d2 = 48;
    req = 3'b010;
    tick();
    wait_quiet(80);
    chk("t6_coinc_err", 32'(resp_err), 32'd0);
    allow_tmo = 1'b0; chk_lat = 1'b0; rand_delays = 1'b1;
`endif

    // Randomized traffic
    use_forced = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = req | N'($urandom);
      if ($urandom_range(0, 2) == 0)
        for (int j = 0; j < N; j++) req_cmd[j*16 +: 16] = 16'($urandom);
      tick();
    end
    req = '0;
    tick();
    wait_quiet(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
